// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI master: grant, slave-select setup,
// transfer, done. Define SPI_ARB_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES XFER cycles.
module spi_arbiter #(
   parameter int unsigned SETUP_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [1:0]  req_i,
   input  logic [31:0] wdata0_i,
   input  logic [31:0] wdata1_i,
   input  logic [2:0]  nbytes0_i,
   input  logic [2:0]  nbytes1_i,
   input  logic [4:0]  ss0_i,
   input  logic [4:0]  ss1_i,
   output logic [1:0]  ack_o,
   output logic [1:0]  done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        busy_o,
   output logic        spi_enable_o,
   output logic [31:0] spi_wdata_o,
   output logic [2:0]  spi_bytes_o,
   output logic        spi_reset_fill_o,
   output logic [31:0] spi_ss_o,
   input  logic [31:0] spi_rdata_i,
   input  logic [2:0]  spi_rbytes_i
);

   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : gen_bad_setup
      $error("SETUP_CYCLES must be in 1..15");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..65535");
   end

   localparam logic [3:0] SetupLast = 4'(SETUP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

   state_e      state_q, state_d;
   logic [1:0]  ack_q, done_q;
   logic        err_q, busy_q, en_q, fill_q;
   logic [31:0] rdata_q, wdata_q, ss_q;
   logic [2:0]  bytes_q;
   logic [3:0]  setup_cnt_q;
   logic        win_q, bad_q;
   logic        rr_last_q, rr_seen_q;

   logic        grant_idx;
   logic [31:0] sel_wdata;
   logic [2:0]  sel_nbytes;
   logic [4:0]  sel_ss;
   logic        sel_legal;
   logic [1:0]  grant_oh, win_oh;
   logic        rbytes_hit, tmo_hit;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_q;
   assign tmo_hit = (tmo_cnt_q == TmoLast);
`else
   assign tmo_hit = 1'b0;
`endif

   assign rbytes_hit = (spi_rbytes_i == bytes_q);
   assign win_oh     = {win_q, ~win_q};
   assign grant_oh   = {grant_idx, ~grant_idx};

   // Tie goes to requester 0 until the first completed transfer, then to the one not served last.
   always_comb begin
      grant_idx = 1'b0;
      unique case (req_i)
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = rr_seen_q & ~rr_last_q;
         default: grant_idx = 1'b0;
      endcase
      sel_wdata  = grant_idx ? wdata1_i  : wdata0_i;
      sel_nbytes = grant_idx ? nbytes1_i : nbytes0_i;
      sel_ss     = grant_idx ? ss1_i     : ss0_i;
      sel_legal  = (sel_nbytes != 3'd0) && (sel_nbytes <= 3'd4);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (|req_i) state_d = StSetup;
         StSetup: begin
            if (bad_q) begin
               state_d = StDone;
            end else if (setup_cnt_q == SetupLast) begin
               state_d = StXfer;
            end
         end
         StXfer:  if (rbytes_hit || tmo_hit) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q     <= StIdle;
         ack_q       <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         en_q        <= 1'b0;
         fill_q      <= 1'b0;
         wdata_q     <= '0;
         bytes_q     <= '0;
         ss_q        <= '1;
         setup_cnt_q <= '0;
         win_q       <= 1'b0;
         bad_q       <= 1'b0;
         rr_last_q   <= 1'b0;
         rr_seen_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ack_q   <= '0;
         done_q  <= '0;
         fill_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (|req_i) begin
                  busy_q      <= 1'b1;
                  win_q       <= grant_idx;
                  ack_q       <= grant_oh;
                  fill_q      <= 1'b1;
                  wdata_q     <= sel_wdata;
                  bytes_q     <= sel_nbytes;
                  bad_q       <= ~sel_legal;
                  setup_cnt_q <= '0;
                  // Illegal byte counts never touch the bus.
                  ss_q        <= sel_legal ? ~(32'd1 << sel_ss) : '1;
               end
            end
            StSetup: begin
               if (bad_q) begin
                  done_q  <= win_oh;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  ss_q    <= '1;
               end else if (setup_cnt_q == SetupLast) begin
                  en_q <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end else begin
                  setup_cnt_q <= setup_cnt_q + 4'd1;
               end
            end
            StXfer: begin
               if (rbytes_hit) begin
                  done_q  <= win_oh;
                  err_q   <= 1'b0;
                  rdata_q <= spi_rdata_i;
                  en_q    <= 1'b0;
                  ss_q    <= '1;
               end else if (tmo_hit) begin
                  done_q  <= win_oh;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  en_q    <= 1'b0;
                  ss_q    <= '1;
               end else begin
`ifdef SPI_ARB_TIMEOUT_EN
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
`endif
               end
            end
            StDone: begin
               busy_q    <= 1'b0;
               rr_last_q <= win_q;
               rr_seen_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ack_o            = ack_q;
   assign done_o           = done_q;
   assign err_o            = err_q;
   assign rdata_o          = rdata_q;
   assign busy_o           = busy_q;
   assign spi_enable_o     = en_q;
   assign spi_wdata_o      = wdata_q;
   assign spi_bytes_o      = bytes_q;
   assign spi_reset_fill_o = fill_q;
   assign spi_ss_o         = ss_q;

endmodule
